// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter fetch stage.
// The FSM encoding lives here so the top and the bench agree on one definition.
package pc_pkg;

  localparam int PC_WIDTH = 16;

  localparam logic [PC_WIDTH-1:0] PC_RESET_ADDR = 16'h0000;
  localparam logic [PC_WIDTH-1:0] PC_STEP       = 16'h0001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

endpackage

// File: rtl/sumador.sv
// Plain WIDTH-bit adder; the carry out is discarded so results wrap modulo 2^WIDTH.
module sumador #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C
);

  assign C = A + B;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the PC, presents it to instruction memory under
// valid/ready, and advances through the external sumador adder.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              WIDTH      = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR),
  parameter logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             halt,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_seq,
  output logic             halted
);

  pc_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             halted_q, halted_d;
  logic [WIDTH-1:0] pc_seq_w;
  logic             accept;

  sumador #(
    .WIDTH(WIDTH)
  ) u_sumador (
    .A(pc_q),
    .B(STEP),
    .C(pc_seq_w)
  );

  // A handshake during stall is visible to memory but must not advance the PC.
  assign accept = fetch_valid_q && fetch_ready && !stall;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = 1'b0;
    halted_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALTED;
        end else if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else if (br_valid) begin
          pc_d = br_target;
        end else if (accept) begin
          pc_d = pc_seq_w;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    fetch_valid_d = (state_d == RUN);
    halted_d      = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_ADDR;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign pc_out      = pc_q;
  assign pc_seq      = pc_seq_w;
  assign fetch_valid = fetch_valid_q;
  assign halted      = halted_q;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter stage that sits directly upstream of the 16-bit `sumador` adder. It holds the registered PC, feeds it to the adder as operand A with STEP as operand B, and takes the adder sum back as the sequential next address. It also presents fetch addresses to instruction memory under a valid/ready handshake, with stall, branch-redirect and halt control.

## Interface
- `WIDTH`, default 16: PC and address width; must match the `sumador` width.
- `RESET_ADDR`, default 16'h0000: PC value loaded by reset.
- `STEP`, default 16'h0001: increment per accepted fetch (word-addressed).

- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset; takes effect at the next rising `clk` and overrides every other input.
- `start`, input, 1: leave IDLE and begin fetching.
- `stall`, input, 1: hold the PC; the handshake is not consumed.
- `br_valid`, input, 1: redirect request.
- `br_target`, input, WIDTH: redirect address.
- `halt`, input, 1: stop fetching permanently until reset.
- `fetch_ready`, input, 1: instruction memory accepts the address.
- `fetch_valid`, output, 1: `pc_out` is a valid fetch address.
- `pc_out`, output, WIDTH: registered current PC.
- `pc_seq`, output, WIDTH: `pc_out + STEP` from the `sumador` instance; combinational.
- `halted`, output, 1: high in the HALTED state.

## Operation
- FSM states, encoded in the package: IDLE, RUN, HALTED.
- **Reset:** state becomes IDLE, `pc_out` = RESET_ADDR, `fetch_valid` = 0, `halted` = 0. `pc_seq` follows `pc_out` (RESET_ADDR+STEP).
- **IDLE**
  - `fetch_valid` = 0.
  - `start` = 1 moves to RUN; PC is unchanged.
  - `br_valid` is ignored.
  - `halt` moves to HALTED.
- **RUN:** `fetch_valid` = 1. Per-cycle priority, highest first:
  1. `halt`: go to HALTED, PC holds, the pending fetch is dropped.
  2. `br_valid`: PC takes `br_target`. This overrides `stall`, and happens with or without `fetch_ready`.
  3. `stall`: PC holds.
  4. `fetch_valid && fetch_ready`: PC takes `pc_seq`.
  5. Otherwise: PC holds, and `pc_out` stays stable while valid is high.
- **HALTED:** `fetch_valid` = 0, `halted` = 1, PC frozen. Only `rst` exits.
- **Arithmetic:** modulo 2^WIDTH with carry discarded, so 16'hFFFF + 1 wraps to 16'h0000 with no flag.
- **Branch target:** loaded unmodified; no alignment check.
- **Stall:** does not deassert `fetch_valid`. Memory may still see the address, but a handshake during stall does not advance the PC. The downstream stage must qualify with `!stall`.

## Timing
- All outputs except `pc_seq` are registered.
- `pc_seq` is valid in the same cycle as `pc_out`; one adder delay.
- Accepted fetch: PC advances 1 cycle after the cycle where valid, ready and !stall are all high. Back-to-back acceptance gives one address per cycle.
- Branch: `pc_out` = `br_target` in the cycle after `br_valid`. An address handshaked in the same cycle as the branch counts as fetched, but the PC does not advance past it.
- `start` to first `fetch_valid`: 1 cycle.
- `halt` to `fetch_valid` = 0 and `halted` = 1: 1 cycle.
- `rst` in mid-RUN, mid-stall or in HALTED: the next cycle shows the full reset values.
- `halt` and `br_valid` together: halt wins and the PC does not load the target.

## Structure
- Package `pc_pkg` holds:
  - state enum `pc_state_t` (IDLE, RUN, HALTED);
  - `PC_WIDTH` = 16;
  - default `PC_RESET_ADDR` and `PC_STEP` constants.
- The only sub-module is the existing `sumador`: A=`pc_out`, B=STEP, C=`pc_seq`. There is no separate incrementer.
- Contents: one `always_ff` for state and PC, one `always_comb` for next state, next PC and outputs.

## Test plan
- **Reset then start:** rst for 2 cycles, then start=1 with fetch_ready=1 held for 4 cycles. Required: `pc_out` = 0,0,1,2,3; `fetch_valid` rises 1 cycle after start; `pc_seq` always equals `pc_out`+1.
- **Backpressure and stall:** in RUN at PC=5, hold fetch_ready=0 for 3 cycles, then stall=1 with ready=1 for 2 cycles. Required: PC stays 5 throughout, `fetch_valid` stays 1, and PC=6 one cycle after both are released.
- **Branch priority:** at PC=3 assert br_valid with br_target=16'h0040 together with stall=1 and ready=0. Required: PC=16'h0040 next cycle, then 16'h0041 after one accepted fetch.
- **Wrap-around:** branch to 16'hFFFF, then one accepted fetch. Required: `pc_seq` = 16'h0000 and PC = 16'h0000.
- **Halt:** in RUN assert halt with br_valid and br_target=16'h0100 in the same cycle. Required: `halted`=1 and `fetch_valid`=0 next cycle, PC unchanged; start and branch are ignored until rst.
- **Reset mid-operation:** rst during back-to-back fetches at PC=16'h0010. Required: next cycle shows IDLE, `pc_out`=RESET_ADDR, `fetch_valid`=0.
